// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall, memory-freeze and branch-flush control for the 5-stage core.
// Optional feature macro: HAZARD_STALL_STATS_EN builds the saturating stall_count counter.
`ifndef SEL_MEM_AS_RES
`define SEL_MEM_AS_RES 2'b01
`endif

module hazard_ctrl_unit #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int LOAD_LAT            = 1,
    parameter int MEM_TIMEOUT         = 255,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           inst_mem_hazard,
    input  logic                           data_mem_hazard,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                           rs1_used_ID,
    input  logic                           rs2_used_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic                           reg_write_EX,
    input  logic [1:0]                     result_sel_EX,
    input  logic                           branch_taken_EX,
    output logic                           stall_PC_IF,
    output logic                           stall_IF_ID,
    output logic                           stall_ID_EX,
    output logic                           stall_EX_MEM,
    output logic                           flush_IF_ID,
    output logic                           flush_ID_EX,
    output logic                           mem_timeout,
    output logic [CNT_WIDTH-1:0]           stall_count
);

    localparam int SB_DEPTH = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam int WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERROR
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                timeout_q;
    logic                mem;
    logic                frozen;
    logic                load_ex;
    logic                sb_hit1;
    logic                sb_hit2;
    logic                hit1;
    logic                hit2;
    logic                load_use;

    assign mem     = inst_mem_hazard || data_mem_hazard;
    assign frozen  = mem || (state == ST_ERROR);
    assign load_ex = (result_sel_EX == `SEL_MEM_AS_RES) && reg_write_EX && (rd_EX != '0);

    // Older loads still waiting for their data; the slot behind a bubble we inserted is never a load.
    if (LOAD_LAT > 1) begin : g_sb
        logic [SB_DEPTH-1:0]                          sb_valid;
        logic [SB_DEPTH-1:0][REGISTER_ADDR_WIDTH-1:0] sb_rd;
        logic                                         ex_bubble;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sb_valid  <= '0;
                sb_rd     <= '0;
                ex_bubble <= 1'b0;
            end else if (!frozen) begin
                sb_valid[0] <= load_ex && !ex_bubble;
                sb_rd[0]    <= rd_EX;
                for (int i = 1; i < SB_DEPTH; i++) begin
                    sb_valid[i] <= sb_valid[i-1];
                    sb_rd[i]    <= sb_rd[i-1];
                end
                ex_bubble <= flush_ID_EX;
            end
        end

        always_comb begin
            sb_hit1 = 1'b0;
            sb_hit2 = 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (sb_valid[i] && (sb_rd[i] == rs1_ID)) sb_hit1 = 1'b1;
                if (sb_valid[i] && (sb_rd[i] == rs2_ID)) sb_hit2 = 1'b1;
            end
        end
    end else begin : g_no_sb
        assign sb_hit1 = 1'b0;
        assign sb_hit2 = 1'b0;
    end

    assign hit1     = (rs1_ID != '0) && ((load_ex && (rd_EX == rs1_ID)) || sb_hit1);
    assign hit2     = (rs2_ID != '0) && ((load_ex && (rd_EX == rs2_ID)) || sb_hit2);
    assign load_use = (rs1_used_ID && hit1) || (rs2_used_ID && hit2);

    // Watchdog: counts consecutive memory-hazard cycles; ERROR is only left through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == ST_ERROR);
            case (state)
                ST_IDLE: begin
                    if (mem) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!mem) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state <= ST_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERROR: state <= ST_ERROR;
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_PC_IF  = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        if (rst_n) begin
            if (frozen) begin
                stall_PC_IF  = 1'b1;
                stall_IF_ID  = 1'b1;
                stall_ID_EX  = 1'b1;
                stall_EX_MEM = 1'b1;
            end else if (branch_taken_EX) begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end else if (load_use) begin
                stall_PC_IF = 1'b1;
                stall_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end
        end
    end

    assign mem_timeout = rst_n && timeout_q;

`ifdef HAZARD_STALL_STATS_EN
    logic [CNT_WIDTH-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (stall_PC_IF && (stat_q != '1)) begin
            stat_q <= stat_q + CNT_WIDTH'(1);
        end
    end

    assign stall_count = rst_n ? stat_q : '0;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed scoreboard bench driving a LOAD_LAT=1 and a LOAD_LAT=3 instance in lockstep.
// Output vectors are {stall_PC_IF, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, mem_timeout}.
`ifndef SEL_MEM_AS_RES
`define SEL_MEM_AS_RES 2'b01
`endif

module tb_hazard_ctrl_unit;

    localparam logic [1:0] L = `SEL_MEM_AS_RES;
    localparam logic [1:0] A = 2'b00;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] FRZ  = 7'b1111000;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] ERR  = 7'b1111001;

`ifdef HAZARD_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inst_mem_hazard;
    logic       data_mem_hazard;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       rs1_used_ID;
    logic       rs2_used_ID;
    logic [4:0] rd_EX;
    logic       reg_write_EX;
    logic [1:0] result_sel_EX;
    logic       branch_taken_EX;

    logic a_spc, a_sif, a_sie, a_sem, a_fif, a_fie, a_to;
    logic b_spc, b_sif, b_sie, b_sem, b_fif, b_fie, b_to;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic [6:0] obs_a;
    logic [6:0] obs_b;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];
    string       tag_q[$];

    assign obs_a = {a_spc, a_sif, a_sie, a_sem, a_fif, a_fie, a_to};
    assign obs_b = {b_spc, b_sif, b_sie, b_sem, b_fif, b_fie, b_to};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REGISTER_ADDR_WIDTH(5),
        .LOAD_LAT(1),
        .MEM_TIMEOUT(8),
        .CNT_WIDTH(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .inst_mem_hazard(inst_mem_hazard), .data_mem_hazard(data_mem_hazard),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .reg_write_EX(reg_write_EX), .result_sel_EX(result_sel_EX),
        .branch_taken_EX(branch_taken_EX),
        .stall_PC_IF(a_spc), .stall_IF_ID(a_sif), .stall_ID_EX(a_sie), .stall_EX_MEM(a_sem),
        .flush_IF_ID(a_fif), .flush_ID_EX(a_fie), .mem_timeout(a_to), .stall_count(a_cnt)
    );

    hazard_ctrl_unit #(
        .REGISTER_ADDR_WIDTH(5),
        .LOAD_LAT(3),
        .MEM_TIMEOUT(8),
        .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .inst_mem_hazard(inst_mem_hazard), .data_mem_hazard(data_mem_hazard),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .reg_write_EX(reg_write_EX), .result_sel_EX(result_sel_EX),
        .branch_taken_EX(branch_taken_EX),
        .stall_PC_IF(b_spc), .stall_IF_ID(b_sif), .stall_ID_EX(b_sie), .stall_EX_MEM(b_sem),
        .flush_IF_ID(b_fif), .flush_ID_EX(b_fie), .mem_timeout(b_to), .stall_count(b_cnt)
    );

    task automatic applyStimulus(input string tag, input logic rv, input logic imh, input logic dmh,
                                 input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                 input logic br, input logic [4:0] r1, input logic u1,
                                 input logic [4:0] r2, input logic u2,
                                 input logic [6:0] ea, input logic [6:0] eb);
        rst_n           = rv;
        inst_mem_hazard = imh;
        data_mem_hazard = dmh;
        rd_EX           = rd;
        reg_write_EX    = rw;
        result_sel_EX   = sel;
        branch_taken_EX = br;
        rs1_ID          = r1;
        rs1_used_ID     = u1;
        rs2_ID          = r2;
        rs2_used_ID     = u2;
        exp_q.push_back({ea, eb});
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        logic [13:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries required=1 entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (obs_a === e[13:7]) else begin
            bad++;
            $error("[TB] FAIL %s lat1 observed=%b expected=%b", t, obs_a, e[13:7]);
        end
        total++;
        assert (obs_b === e[6:0]) else begin
            bad++;
            $error("[TB] FAIL %s lat3 observed=%b expected=%b", t, obs_b, e[6:0]);
        end
    endtask

    task automatic checkCount(input string tag, input logic [1:0] exp_cnt);
        logic [1:0] want;
        want = STATS ? exp_cnt : 2'd0;
        total++;
        assert (a_cnt === want) else begin
            bad++;
            $error("[TB] FAIL %s lat1 stall_count observed=%0d expected=%0d", tag, a_cnt, want);
        end
        total++;
        assert (b_cnt === want) else begin
            bad++;
            $error("[TB] FAIL %s lat3 stall_count observed=%0d expected=%0d", tag, b_cnt, want);
        end
    endtask

    // One pipeline cycle: drive after the edge, compare mid-cycle, then advance.
    task automatic cyc(input string tag, input logic rv, input logic imh, input logic dmh,
                       input logic [4:0] rd, input logic rw, input logic [1:0] sel, input logic br,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [6:0] ea, input logic [6:0] eb);
        applyStimulus(tag, rv, imh, dmh, rd, rw, sel, br, r1, u1, r2, u2, ea, eb);
        #3;
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        @(posedge clk);
        #1;
        $display("[TB] starting hazard_ctrl_unit bench");

        cyc("rst_with_hazard", 0, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        cyc("rst_idle",        0, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        checkCount("count_in_reset", 2'd0);
        cyc("idle",            1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);

        cyc("lu_x5",           1, 0, 0, 5, 1, L, 0, 5, 1, 0, 0, LU,   LU);
        cyc("lu_x5_age1",      1, 0, 0, 0, 0, A, 0, 5, 1, 0, 0, NONE, LU);
        cyc("lu_x5_age2",      1, 0, 0, 0, 0, A, 0, 5, 1, 0, 0, NONE, LU);
        cyc("lu_x5_released",  1, 0, 0, 0, 0, A, 0, 5, 1, 0, 0, NONE, NONE);
        cyc("rs1_unused",      1, 0, 0, 5, 1, L, 0, 5, 0, 0, 0, NONE, NONE);
        cyc("rs1_unused_age",  1, 0, 0, 0, 0, A, 0, 5, 0, 0, 0, NONE, NONE);
        cyc("drain",           1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        cyc("load_rd_x0",      1, 0, 0, 0, 1, L, 0, 0, 1, 0, 1, NONE, NONE);
        cyc("load_no_write",   1, 0, 0, 5, 0, L, 0, 5, 1, 0, 0, NONE, NONE);
        cyc("alu_writer",      1, 0, 0, 5, 1, A, 0, 5, 1, 0, 0, NONE, NONE);

        cyc("x7_load",         1, 0, 0, 7, 1, L, 0, 1, 1, 0, 0, NONE, NONE);
        cyc("x7_indep1",       1, 0, 0, 1, 1, A, 0, 2, 1, 0, 0, NONE, NONE);
        cyc("x7_use_rs2",      1, 0, 0, 2, 1, A, 0, 3, 1, 7, 1, NONE, LU);
        cyc("x7_released",     1, 0, 0, 0, 0, A, 0, 3, 1, 7, 1, NONE, NONE);

        cyc("x9_lu",           1, 0, 0, 9, 1, L, 0, 9, 1, 0, 0, LU,   LU);
        for (int k = 0; k < 4; k++)
            cyc($sformatf("x9_dmem_freeze%0d", k), 1, 0, 1, 0, 0, A, 0, 9, 1, 0, 0, FRZ, FRZ);
        cyc("x9_after_freeze", 1, 0, 0, 0, 0, A, 0, 9, 1, 0, 0, NONE, LU);
        cyc("x9_age",          1, 0, 0, 0, 0, A, 0, 9, 1, 0, 0, NONE, LU);
        cyc("x9_released",     1, 0, 0, 0, 0, A, 0, 9, 1, 0, 0, NONE, NONE);

        cyc("x4_lu_rs2",       1, 0, 0, 4, 1, L, 0, 0, 0, 4, 1, LU,   LU);
        cyc("branch_over_lu",  1, 0, 0, 0, 0, A, 1, 0, 0, 4, 1, BR,   BR);
        cyc("branch_with_ld",  1, 0, 0, 6, 1, L, 1, 6, 1, 0, 0, BR,   BR);
        cyc("post_branch",     1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        cyc("branch_frozen",   1, 1, 0, 0, 0, A, 1, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("branch_deferred", 1, 0, 0, 0, 0, A, 1, 0, 0, 0, 0, BR,   BR);
        cyc("idle2",           1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);

        for (int k = 0; k < 20; k++)
            cyc($sformatf("timeout_k%0d", k), 1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0,
                (k >= 10) ? ERR : FRZ, (k >= 10) ? ERR : FRZ);
        for (int k = 0; k < 3; k++)
            cyc($sformatf("error_hold%0d", k), 1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, ERR, ERR);
        cyc("error_blocks_br", 1, 0, 0, 3, 1, L, 1, 3, 1, 0, 0, ERR,  ERR);
        cyc("rst_in_error",    0, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        cyc("after_err_rst",   1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);

        cyc("wait_a",          1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("wait_b",          1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("rst_in_wait",     0, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        for (int k = 0; k < 8; k++)
            cyc($sformatf("hazard8_k%0d", k), 1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ, FRZ);
        cyc("hazard8_no_error", 1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        for (int k = 0; k < 9; k++)
            cyc($sformatf("hazard9_k%0d", k), 1, 0, 1, 0, 0, A, 0, 0, 0, 0, 0, FRZ, FRZ);
        cyc("hazard9_error",   1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("hazard9_flag",    1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, ERR,  ERR);

        cyc("rst_stats",       0, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        cyc("stats_idle",      1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        checkCount("count_cleared", 2'd0);
        cyc("stats_stall0",    1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("stats_stall1",    1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        checkCount("count_two", 2'd2);
        cyc("stats_stall2",    1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("stats_stall3",    1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        cyc("stats_stall4",    1, 1, 0, 0, 0, A, 0, 0, 0, 0, 0, FRZ,  FRZ);
        checkCount("count_saturated", 2'd3);
        cyc("stats_release",   1, 0, 0, 0, 0, A, 0, 0, 0, 0, 0, NONE, NONE);
        checkCount("count_held", 2'd3);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation pipeline hazard controller for the 5-stage RISC-V core.
- Load-use detection compares rs1/rs2 against the load destination, gated by per-operand "used" flags.
- A LOAD_LAT-deep scoreboard of in-flight load destinations supports multi-cycle data memory.
- Memory hazards freeze the pipeline instead of flushing it; an FSM with a timeout watchdog handles them. Branch redirect flushes are handled here too.
- Sits in ID/EX beside the forwarding unit; drives all PC and pipeline-register stall/flush controls.

Parameters:
REGISTER_ADDR_WIDTH, 5, register index width
LOAD_LAT, 1, cycles after EX before load data is forwardable (1..4)
MEM_TIMEOUT, 255, max consecutive memory-hazard cycles before error (>=1)
CNT_WIDTH, 32, width of optional stall statistics counter

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
inst_mem_hazard  in  1  instruction memory not ready this cycle
data_mem_hazard  in  1  data memory not ready this cycle
rs1_ID  in  REGISTER_ADDR_WIDTH  ID source 1
rs2_ID  in  REGISTER_ADDR_WIDTH  ID source 2
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  REGISTER_ADDR_WIDTH  EX destination
reg_write_EX  in  1  EX instruction writes rd
result_sel_EX  in  2  EX result select; `SEL_MEM_AS_RES marks a load
branch_taken_EX  in  1  EX resolved taken branch/jump
stall_PC_IF  out  1  hold PC
stall_IF_ID  out  1  hold IF/ID
stall_ID_EX  out  1  hold ID/EX
stall_EX_MEM  out  1  hold EX/MEM and MEM/WB
flush_IF_ID  out  1  clear IF/ID
flush_ID_EX  out  1  insert bubble into ID/EX
mem_timeout  out  1  sticky watchdog error
stall_count  out  CNT_WIDTH  stall statistics (optional feature)

Behaviour:
- Single clk; reset synchronous, active-low (rst_n). While rst_n=0: every output 0, FSM=IDLE, scoreboard cleared, wait counter 0.
- load_EX = (result_sel_EX==`SEL_MEM_AS_RES) && reg_write_EX && rd_EX!=0.
- Scoreboard: LOAD_LAT-1 entries {valid, rd}; none when LOAD_LAT=1.
  - Shifts only when not frozen: entry0 <= {load_EX && !flush_ID_EX-bubble-origin, rd_EX}; entry i <= entry i-1; last entry drops.
  - While frozen: holds.
- hit(r) = r!=0 && (load_EX && rd_EX==r || any valid entry with rd==r).
- load_use = (rs1_used_ID && hit(rs1_ID)) || (rs2_used_ID && hit(rs2_ID)).
- FSM states IDLE, WAIT, ERROR; mem = inst_mem_hazard || data_mem_hazard.
  - IDLE: mem -> WAIT, cnt<=1.
  - WAIT: !mem -> IDLE, cnt<=0; mem && cnt==MEM_TIMEOUT -> ERROR; else cnt++.
  - ERROR: stays until reset; mem_timeout=1 (registered, asserted the cycle after entry).
- frozen = mem || state==ERROR. Freeze is combinational from the inputs, same cycle.
- Output priority, combinational; all stall/flush outputs not listed are 0:
  1. frozen: all four stalls = 1, both flushes = 0.
  2. branch_taken_EX: flush_IF_ID = flush_ID_EX = 1; load_use ignored (wrong path).
  3. load_use: stall_PC_IF = stall_IF_ID = 1, flush_ID_EX = 1.
- A branch during a freeze is deferred: EX is held, so the flush fires on the first unfrozen cycle.
- Latency: load-use stall lasts exactly LOAD_LAT cycles minus any forwarding slack. Each stalled cycle re-evaluates, and the scoreboard ages one entry per unfrozen cycle.
- A reset mid-WAIT or mid-ERROR returns to IDLE with mem_timeout cleared.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- Defined: stall_count increments each cycle stall_PC_IF=1, saturates at all-ones, and is reset to 0.
- Undefined: stall_count is tied to 0 and the counter logic is absent.

Test Plan:
- LOAD_LAT=1; load x5 in EX, ID reads rs1=x5 with rs1_used=1 -> one cycle of stall_PC_IF=stall_IF_ID=flush_ID_EX=1, then all 0. Same with rs1_used=0 -> no stall. rd_EX=0 -> no stall.
- LOAD_LAT=3; load x7 then two independent instrs, then a use of x7 in rs2 -> stall while the x7 entry is still valid; released when it ages out.
- data_mem_hazard high 4 cycles during a load-use -> 4 cycles of all stalls=1, no flushes; scoreboard frozen; load-use resolves after release.
- branch_taken_EX coincident with load_use -> flush_IF_ID=flush_ID_EX=1, stall_PC_IF=0.
- MEM_TIMEOUT=8; inst_mem_hazard held 20 cycles -> ERROR; mem_timeout=1 from cycle 10, stalls stay 1 after the hazard drops. rst_n=0 for one cycle -> all outputs 0, state IDLE.
- With HAZARD_STALL_STATS_EN, CNT_WIDTH=2; 5 stall cycles -> stall_count=3 (saturated). Without the macro -> stall_count=0.
